// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, HALT} fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// Circular FIFO of {pc, instr} fetch entries with push/pop/flush.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t      mem_q [DEPTH];
    logic [AW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;
    assign rdata   = mem_q[head_q];
    assign count   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + 1'b1;
            if (do_pop)  head_q <= head_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: entries are only observable once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= wdata;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter, fetch FSM and fetch buffer feeding decode via valid/ready.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH   = 2,
    parameter logic [31:0] EBREAK_WORD = fetch_pkg::EBREAK_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_enable,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted,
    output logic        misalign_fault
);

    import fetch_pkg::*;

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          fault_q, fault_d;
    logic          push, pop;
    logic          buf_full, buf_empty;
    logic [CW-1:0] buf_count;
    fetch_entry_t  head;

    fetch_buffer #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ('{pc: pc_q, instr: imem_instr}),
        .rdata (head),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign imem_addr      = pc_q;
    assign if_valid       = !buf_empty;
    assign if_pc          = head.pc;
    assign if_instr       = head.instr;
    assign halted         = (state_q == HALT);
    assign misalign_fault = fault_q;

    always_comb begin
        pop     = if_valid && if_ready;
        push    = (state_q == FETCH) && fetch_enable && !redirect_valid &&
                  ((buf_count < CW'(BUF_DEPTH)) || pop);
        pc_d    = pc_q;
        state_d = state_q;
        fault_d = fault_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            fault_d = |redirect_pc[1:0];
            state_d = fetch_enable ? FETCH : IDLE;
        end else begin
            if (push) pc_d = pc_q + INSTR_BYTES;
            case (state_q)
                IDLE:    if (fetch_enable) state_d = FETCH;
                FETCH: begin
                    if (!fetch_enable)                          state_d = IDLE;
                    else if (push && imem_instr == EBREAK_WORD) state_d = HALT;
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    a_full_count: assert property (@(posedge clk) disable iff (rst)
        buf_full |-> (buf_count == CW'(BUF_DEPTH)));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a queue-based reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_enable;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;
    logic        misalign_fault;

    logic [31:0] mem [256];

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    int          m_mode;    // 0 idle, 1 fetching, 2 halted
    logic        m_fault;

    logic [98:0] got, exp;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[9:2]];

    instruction_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .BUF_DEPTH  (BUF_DEPTH),
        .EBREAK_WORD(EBREAK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_enable  (fetch_enable),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .halted        (halted),
        .misalign_fault(misalign_fault)
    );

    function automatic logic [98:0] model_outputs();
        logic [63:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 64'd0;
        return {m_q.size() > 0, m_mode == 2, m_fault, m_pc, h};
    endfunction

    function automatic logic [98:0] dut_outputs();
        return {if_valid, halted, misalign_fault, imem_addr,
                if_valid ? {if_pc, if_instr} : 64'd0};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == EBREAK) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc    = RESET_PC;
        m_mode  = 0;
        m_fault = 1'b0;
    endtask

    // Advance one clock: update the model from the current inputs, land on the next negedge.
    task automatic step();
        bit          pop, push;
        logic [31:0] w;
        pop = (m_q.size() > 0) && if_ready;
        w   = mem[m_pc[9:2]];
        if (redirect_valid) begin
            m_q.delete();
            m_pc    = {redirect_pc[31:2], 2'b00};
            m_fault = (redirect_pc[1:0] != 2'b00);
            m_mode  = fetch_enable ? 1 : 0;
        end else begin
            push = (m_mode == 1) && fetch_enable && ((m_q.size() < BUF_DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_pc, w});
                m_pc = m_pc + 32'd4;
            end
            if (m_mode == 0 && fetch_enable)            m_mode = 1;
            else if (m_mode == 1 && !fetch_enable)      m_mode = 0;
            else if (m_mode == 1 && push && w == EBREAK) m_mode = 2;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst            = 1'b1;
        fetch_enable   = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        #1;
        vectors++;
        if ({if_valid, halted, misalign_fault, imem_addr} !== {3'b000, RESET_PC}) begin
            miscompares++;
            $display("FAIL reset_values got=%h exp=%h",
                     {if_valid, halted, misalign_fault, imem_addr}, {3'b000, RESET_PC});
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        apply_reset();
        fetch_enable = 1'b1;
        if_ready     = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            got = dut_outputs(); exp = model_outputs(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL stream cyc=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 2) begin
                vectors++;
                if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, mem[0]}) begin
                    miscompares++;
                    $display("FAIL stream_first got=%h exp=%h",
                             {if_valid, if_pc, if_instr}, {1'b1, 32'h0, mem[0]});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        fetch_enable = 1'b1;
        if_ready     = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            got = dut_outputs(); exp = model_outputs(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL backpressure cyc=%0d got=%h exp=%h", c, got, exp);
            end
        end
        vectors++;
        if ({imem_addr, if_pc} !== {32'h8, 32'h0}) begin
            miscompares++;
            $display("FAIL backpressure_sat got=%h exp=%h", {imem_addr, if_pc}, {32'h8, 32'h0});
        end
        if_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            got = dut_outputs(); exp = model_outputs(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL backpressure_release cyc=%0d got=%h exp=%h", c, got, exp);
            end
            if (c < 2) begin
                vectors++;
                if (if_pc !== 32'h4 + 32'(c) * 32'h4) begin
                    miscompares++;
                    $display("FAIL release_order cyc=%0d got=%h exp=%h",
                             c, if_pc, 32'h4 + 32'(c) * 32'h4);
                end
            end
        end
    endtask

    task automatic test_redirect_flush();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        vectors++;
        if (if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_flush got=%b exp=0", if_valid);
        end
        step();
        vectors++;
        if ({if_valid, if_pc} !== {1'b1, 32'h40}) begin
            miscompares++;
            $display("FAIL redirect_target got=%h exp=%h", {if_valid, if_pc}, {1'b1, 32'h40});
        end
        got = dut_outputs(); exp = model_outputs(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL redirect_model got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        step();
        vectors++;
        if ({imem_addr, misalign_fault} !== {32'h40, 1'b1}) begin
            miscompares++;
            $display("FAIL misalign_set got=%h exp=%h", {imem_addr, misalign_fault}, {32'h40, 1'b1});
        end
        redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        vectors++;
        if ({imem_addr, misalign_fault} !== {32'h80, 1'b0}) begin
            miscompares++;
            $display("FAIL misalign_clear got=%h exp=%h", {imem_addr, misalign_fault}, {32'h80, 1'b0});
        end
    endtask

    task automatic test_ebreak();
        mem[4]         = EBREAK;
        fetch_enable   = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            got = dut_outputs(); exp = model_outputs(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL ebreak cyc=%0d got=%h exp=%h", c, got, exp);
            end
            step();
        end
        vectors++;
        if ({halted, if_valid, imem_addr} !== {1'b1, 1'b0, 32'h14}) begin
            miscompares++;
            $display("FAIL ebreak_halt got=%h exp=%h",
                     {halted, if_valid, imem_addr}, {1'b1, 1'b0, 32'h14});
        end
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        vectors++;
        if ({halted, imem_addr} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL ebreak_resume got=%h exp=%h", {halted, imem_addr}, {1'b0, 32'h0});
        end
        mem[4] = rand_word();
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 6; k++) mem[$urandom_range(0, 255)] = EBREAK;
        for (int c = 0; c < 400; c++) begin
            fetch_enable   = ($urandom_range(0, 7) != 0);
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            step();
            got = dut_outputs(); exp = model_outputs(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, got, exp);
            end
        end
        for (int i = 0; i < 256; i++) mem[i] = rand_word();
    endtask

    task automatic test_async_reset();
        apply_reset();
        mem[1]       = EBREAK;
        fetch_enable = 1'b1;
        if_ready     = 1'b0;
        for (int c = 0; c < 4; c++) step();
        got = dut_outputs(); exp = model_outputs(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL async_pre got=%h exp=%h", got, exp);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({if_valid, halted, misalign_fault, imem_addr} !== {3'b000, RESET_PC}) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=%h",
                     {if_valid, halted, misalign_fault, imem_addr}, {3'b000, RESET_PC});
        end
        @(negedge clk);
        model_reset();
        rst    = 1'b0;
        mem[1] = rand_word();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = rand_word();
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_misalign();
        test_ebreak();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
